imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the c16 instruction-memory interface: receives a program as a byte stream,
//  packs big-endian byte pairs into 16-bit instruction words and writes them into the
//  instruction RAM write port while holding the CPU pipeline. Sits beside the fetch stage on
//  the second RAM port; the fetch stage only reads this memory, this block only writes it.
// PARAMETERS
//  ADDR_W     16    width of wr_addr
//  DEPTH      1024  max words accepted; larger counts are rejected
//  BASE_ADDR  0     RAM address of the first program word
// PORTS
//  clk        in   1       single system clock, all logic on posedge
//  reset_n    in   1       synchronous reset, active low
//  start      in   1       1-cycle request to begin a load; ignored unless in IDLE
//  in_valid   in   1       byte stream valid
//  in_data    in   8       byte stream data
//  in_ready   out  1       byte accepted when in_valid && in_ready on a clk edge
//  wr_en      out  1       RAM write strobe, 1 cycle per word
//  wr_addr    out  ADDR_W  RAM write address
//  wr_data    out  16      RAM write data (instruction word)
//  cpu_hold   out  1       held high while loading; CPU must not fetch/execute
//  done       out  1       1-cycle pulse on successful load
//  error      out  1       sticky load error, cleared by start or reset
// BEHAVIOUR
//  - Reset (reset_n low at edge): state IDLE; all outputs 0; word index 0. RAM contents untouched;
//    reset mid-load abandons the load, already written words remain.
//  - Frame: COUNT (2 bytes, hi first) then COUNT words (2 bytes each, hi first).
//  - States: IDLE -> CNT_HI -> CNT_LO -> DAT_HI <-> DAT_LO -> [CSUM_HI -> CSUM_LO] -> DONE -> IDLE;
//    any -> ERR on rejection. ERR -> CNT_HI on start; error clears in that same edge.
//  - IDLE: in_ready=0, cpu_hold=0. start -> CNT_HI, cpu_hold=1 from the next cycle.
//  - in_ready=1 in CNT_*/DAT_*/CSUM_*, else 0. Stall on in_valid=0 any number of cycles.
//  - CNT_LO accept: COUNT==0 or COUNT>DEPTH -> ERR, no writes.
//  - DAT_LO accept: next cycle wr_en=1, wr_data={hi,lo}, wr_addr=BASE_ADDR+idx (truncated to
//    ADDR_W, wraps); idx++. Latency 1 cycle from low byte handshake. Max rate 1 word / 2 cycles.
//  - After word COUNT-1: DONE (without CHECKSUM_EN) or CSUM_HI (with).
//  - DONE: done=1, cpu_hold=1 for exactly 1 cycle; next cycle IDLE, cpu_hold=0.
//  - ERR: error=1, cpu_hold stays 1 (CPU must not run partial image), in_ready=0.
//  - start while not IDLE/ERR: ignored. start and in_valid in same IDLE cycle: byte not taken.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the last word a 16-bit checksum (hi first) follows;
//    expected = sum of all words mod 2^16. Match -> DONE; mismatch -> ERR (words already written).
//  Undefined: no checksum bytes expected; DONE after the last word; no accumulator logic.
// STRUCTURE
//  - Package c16_pkg: loader state enum, C16_WORD_W=16, C16_BYTE_W=8 shared with CPU stages.
//  - One sub-module imem_word_asm: byte-pair packer (hi/lo register, word_valid pulse);
//    FSM, index counter, checksum accumulator stay in imem_loader.
// TESTING
//  1 reset_n=0 mid DAT_LO -> all outputs 0, state IDLE; start then reload from scratch succeeds.
//  2 start; bytes 00 02 12 34 AB CD -> writes (0,0x1234),(1,0xABCD), done pulse, cpu_hold falls next cycle.
//  3 same frame with in_valid toggled every other cycle -> identical writes, no duplicates/drops.
//  4 COUNT=0x0000 and COUNT=DEPTH+1 -> error=1, no wr_en, cpu_hold=1; start clears error.
//  5 CHECKSUM_EN: 00 02 12 34 AB CD BE 01 -> done; checksum BE 02 -> error=1 after 2 writes.
//  6 BASE_ADDR=0xFFFF, ADDR_W=16, COUNT=2 -> writes to 0xFFFF then 0x0000; start during load ignored.

Source files
------------

// File: rtl/c16_pkg.sv
// Shared c16 definitions: data widths used by the CPU stages and the loader state encoding.
package c16_pkg;

  localparam int unsigned C16_WORD_W = 16;
  localparam int unsigned C16_BYTE_W = 8;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_CNT_HI,
    LD_CNT_LO,
    LD_DAT_HI,
    LD_DAT_LO,
    LD_CSUM_HI,
    LD_CSUM_LO,
    LD_DONE,
    LD_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Byte-pair packer: latches the high byte, then emits {hi, lo} with a 1-cycle word_valid.
module imem_word_asm
  import c16_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hi_load,
  input  logic                  lo_load,
  input  logic [C16_BYTE_W-1:0] byte_in,
  output logic [C16_BYTE_W-1:0] hi_byte,
  output logic [C16_WORD_W-1:0] word,
  output logic                  word_valid
);

  // High-byte holding register, packed word and its strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_byte    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_load;
      if (hi_load) hi_byte <= byte_in;
      if (lo_load) word <= {hi_byte, byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a COUNT + words byte frame and writes the words into the
// instruction RAM while holding the CPU. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import c16_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [C16_BYTE_W-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [C16_WORD_W-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  loader_state_e           state_q, state_d;
  logic [C16_WORD_W-1:0]   idx_q;
  logic [C16_WORD_W-1:0]   count_q;
  logic [C16_BYTE_W-1:0]   hi_byte;
  logic [C16_WORD_W-1:0]   rx_word;
  logic                    accept;
  logic                    restart;
  logic                    hi_load;
  logic                    lo_load;

  assign accept  = in_valid && in_ready;
  assign rx_word = {hi_byte, in_data};
  assign restart = start && (state_q == LD_IDLE || state_q == LD_ERR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [C16_WORD_W-1:0] csum_q;

  // Running mod-2^16 sum of every data word of the current load.
  always_ff @(posedge clk) begin
    if (!reset_n)     csum_q <= '0;
    else if (restart) csum_q <= '0;
    else if (lo_load) csum_q <= csum_q + rx_word;
  end
`endif

  imem_word_asm u_word_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .hi_load    (hi_load),
    .lo_load    (lo_load),
    .byte_in    (in_data),
    .hi_byte    (hi_byte),
    .word       (wr_data),
    .word_valid (wr_en)
  );

  // Next-state logic and byte-load strobes for the packer.
  always_comb begin
    state_d = state_q;
    hi_load = 1'b0;
    lo_load = 1'b0;
    case (state_q)
      LD_IDLE: if (start) state_d = LD_CNT_HI;
      LD_CNT_HI: begin
        if (accept) begin
          hi_load = 1'b1;
          state_d = LD_CNT_LO;
        end
      end
      LD_CNT_LO: begin
        if (accept) begin
          if (rx_word == '0 || 32'(rx_word) > DEPTH) state_d = LD_ERR;
          else                                       state_d = LD_DAT_HI;
        end
      end
      LD_DAT_HI: begin
        if (accept) begin
          hi_load = 1'b1;
          state_d = LD_DAT_LO;
        end
      end
      LD_DAT_LO: begin
        if (accept) begin
          lo_load = 1'b1;
          if (idx_q == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = LD_CSUM_HI;
`else
            state_d = LD_DONE;
`endif
          end else begin
            state_d = LD_DAT_HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CSUM_HI: begin
        if (accept) begin
          hi_load = 1'b1;
          state_d = LD_CSUM_LO;
        end
      end
      LD_CSUM_LO: begin
        if (accept) state_d = (rx_word == csum_q) ? LD_DONE : LD_ERR;
      end
`endif
      LD_DONE: state_d = LD_IDLE;
      LD_ERR:  if (start) state_d = LD_CNT_HI;
      default: state_d = LD_IDLE;
    endcase
  end

  // State, counters and registered status outputs decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= LD_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      wr_addr  <= '0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= state_d inside {LD_CNT_HI, LD_CNT_LO, LD_DAT_HI, LD_DAT_LO,
                                  LD_CSUM_HI, LD_CSUM_LO};
      cpu_hold <= (state_d != LD_IDLE);
      done     <= (state_d == LD_DONE);
      error    <= (state_d == LD_ERR);
      if (state_q == LD_CNT_LO && accept) count_q <= rx_word;
      if (restart) begin
        idx_q <= '0;
      end else if (lo_load) begin
        wr_addr <= ADDR_W'(BASE_ADDR + 32'(idx_q));
        idx_q   <= idx_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus reset / start corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [15:0] wr_addr, wr_data;
  logic        h_in_ready, h_wr_en, h_cpu_hold, h_done, h_error;
  logic [15:0] h_wr_addr, h_wr_data;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [31:0] wq[$];
  logic [31:0] hq[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(16), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  imem_loader #(.ADDR_W(16), .DEPTH(1024), .BASE_ADDR(32'hFFFF)) dut_hi (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(h_in_ready), .wr_en(h_wr_en), .wr_addr(h_wr_addr), .wr_data(h_wr_data),
    .cpu_hold(h_cpu_hold), .done(h_done), .error(h_error)
  );

  // Record every RAM write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en)   wq.push_back({wr_addr, wr_data});
    if (h_wr_en) hq.push_back({h_wr_addr, h_wr_data});
    if (done)    done_cnt++;
  end

  typedef struct packed {
    bit [3:0]        len;
    bit [95:0]       s;      // first byte in the top bits
    bit              gap;
    bit              exp_done;
    bit              exp_err;
    bit [1:0]        nwr;
    bit [1:0][15:0]  wd;
  } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int N_VEC = 7;
`else
  localparam int N_VEC = 6;
`endif
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " in_ready after start"}, 32'(in_ready), 32'd1);
    check({tag, " cpu_hold after start"}, 32'(cpu_hold), 32'd1);
    check({tag, " error after start"}, 32'(error), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready timeout: got 0, expected 1 within 20 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_range(input bit [95:0] s, input int from, input int to, input bit gap);
    for (int k = from; k < to; k++) send_byte(s[95-8*k -: 8], gap);
  endtask

  task automatic check_writes(input string tag, input int w0, input int h0, input int n,
                              input bit [1:0][15:0] wd);
    check({tag, " write count"}, 32'(wq.size() - w0), 32'(n));
    check({tag, " hi write count"}, 32'(hq.size() - h0), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (wq.size() > w0 + k)
        check($sformatf("%s write %0d", tag, k), wq[w0+k], {16'(k), wd[k]});
      if (hq.size() > h0 + k)
        check($sformatf("%s hi write %0d", tag, k), hq[h0+k], {16'(32'hFFFF + k), wd[k]});
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, " wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, " wr_data"}, 32'(wr_data), 32'd0);
    check({tag, " hi wr_addr"}, 32'(h_wr_addr), 32'd0);
  endtask

  initial begin
    int w0, h0, d0;
    bit [1:0][15:0] good_wd;
    good_wd = {16'hABCD, 16'h1234};

`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[0] = '{len: 4'd8, s: {64'h00021234ABCDBE01, 32'h0}, gap: 1'b0, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd2, wd: good_wd};
    vecs[1] = '{len: 4'd8, s: {64'h00021234ABCDBE01, 32'h0}, gap: 1'b1, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd2, wd: good_wd};
    vecs[4] = '{len: 4'd6, s: {48'h0001FFFFFFFF, 48'h0}, gap: 1'b0, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd1, wd: {16'h0, 16'hFFFF}};
    vecs[6] = '{len: 4'd8, s: {64'h00021234ABCDBE02, 32'h0}, gap: 1'b0, exp_done: 1'b0,
                exp_err: 1'b1, nwr: 2'd2, wd: good_wd};
`else
    vecs[0] = '{len: 4'd6, s: {48'h00021234ABCD, 48'h0}, gap: 1'b0, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd2, wd: good_wd};
    vecs[1] = '{len: 4'd6, s: {48'h00021234ABCD, 48'h0}, gap: 1'b1, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd2, wd: good_wd};
    vecs[4] = '{len: 4'd4, s: {32'h0001FFFF, 64'h0}, gap: 1'b0, exp_done: 1'b1,
                exp_err: 1'b0, nwr: 2'd1, wd: {16'h0, 16'hFFFF}};
`endif
    vecs[2] = '{len: 4'd2, s: {16'h0000, 80'h0}, gap: 1'b0, exp_done: 1'b0,
                exp_err: 1'b1, nwr: 2'd0, wd: '0};
    vecs[3] = '{len: 4'd2, s: {16'h0401, 80'h0}, gap: 1'b0, exp_done: 1'b0,
                exp_err: 1'b1, nwr: 2'd0, wd: '0};
    vecs[5] = '{len: 4'd2, s: {16'hFFFF, 80'h0}, gap: 1'b0, exp_done: 1'b0,
                exp_err: 1'b1, nwr: 2'd0, wd: '0};

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int i = 0; i < N_VEC; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      w0 = wq.size();
      h0 = hq.size();
      d0 = done_cnt;
      do_start(tag);
      send_range(vecs[i].s, 0, int'(vecs[i].len), vecs[i].gap);
      check({tag, " done at end"}, 32'(done), 32'(vecs[i].exp_done));
      check({tag, " error at end"}, 32'(error), 32'(vecs[i].exp_err));
      tick();
      check({tag, " done after"}, 32'(done), 32'd0);
      check({tag, " cpu_hold after"}, 32'(cpu_hold), 32'(vecs[i].exp_err));
      tick();
      tick();
      check({tag, " error held"}, 32'(error), 32'(vecs[i].exp_err));
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd0);
      check({tag, " done pulses"}, 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check_writes(tag, w0, h0, int'(vecs[i].nwr), vecs[i].wd);
    end

    // Reset while waiting in DAT_LO, then a clean reload.
    do_start("rst");
    send_range(vecs[0].s, 0, 3, 1'b0);
    reset_n = 1'b0;
    tick();
    check_idle_zero("mid reset");
    reset_n = 1'b1;
    tick();
    w0 = wq.size();
    h0 = hq.size();
    d0 = done_cnt;
    do_start("reload");
    send_range(vecs[0].s, 0, int'(vecs[0].len), 1'b0);
    check("reload done", 32'(done), 32'd1);
    tick();
    check("reload cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("reload done pulses", 32'(done_cnt - d0), 32'd1);
    check_writes("reload", w0, h0, 2, good_wd);

    // start with in_valid in IDLE must not take the byte; start mid-load is ignored.
    w0 = wq.size();
    h0 = hq.size();
    d0 = done_cnt;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    send_range(vecs[0].s, 0, 3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_range(vecs[0].s, 3, int'(vecs[0].len), 1'b0);
    check("ignore done", 32'(done), 32'd1);
    check("ignore error", 32'(error), 32'd0);
    tick();
    tick();
    check("ignore done pulses", 32'(done_cnt - d0), 32'd1);
    check_writes("ignore", w0, h0, 2, good_wd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
